// File: rtl/wash_pkg.sv
// wash_pkg: constants shared by the wash sequencer and the display logic.
//   - wash_state_e : machine state codes (code 7 is illegal)
//   - STn_MSB/STn_LSB : bit positions of each stage field in the countdown word
//   - MSG_W        : width of the countdown word
//   - stage_lsb()  : LSB position of a stage field selected by index
package wash_pkg;

   localparam int MSG_W = 26;

   typedef enum logic [2:0] {
      shutDownST = 3'd0,
      beginST    = 3'd1,
      setST      = 3'd2,
      runST      = 3'd3,
      errorST    = 3'd4,
      pauseST    = 3'd5,
      finishST   = 3'd6,
      illegalST  = 3'd7
   } wash_state_e;

   localparam int ST7_MSB = 25;
   localparam int ST7_LSB = 23;
   localparam int ST6_MSB = 22;
   localparam int ST6_LSB = 19;
   localparam int ST5_MSB = 18;
   localparam int ST5_LSB = 16;
   localparam int ST4_MSB = 15;
   localparam int ST4_LSB = 13;
   localparam int ST3_MSB = 12;
   localparam int ST3_LSB = 10;
   localparam int ST2_MSB = 9;
   localparam int ST2_LSB = 6;
   localparam int ST1_MSB = 5;
   localparam int ST1_LSB = 3;
   localparam int ST0_MSB = 2;
   localparam int ST0_LSB = 0;

   function automatic logic [4:0] stage_lsb(input logic [2:0] idx);
      logic [4:0] lsb;
      case (idx)
         3'd7:    lsb = 5'(ST7_LSB);
         3'd6:    lsb = 5'(ST6_LSB);
         3'd5:    lsb = 5'(ST5_LSB);
         3'd4:    lsb = 5'(ST4_LSB);
         3'd3:    lsb = 5'(ST3_LSB);
         3'd2:    lsb = 5'(ST2_LSB);
         3'd1:    lsb = 5'(ST1_LSB);
         default: lsb = 5'(ST0_LSB);
      endcase
      return lsb;
   endfunction

endpackage

// File: rtl/stage_decrementer.sv
// stage_decrementer: combinational one-step countdown of the programme word.
// Ports:
//   word      in  26 : current countdown word
//   decWord   out 26 : word with the highest non-zero stage field decremented
//   fieldZero out 1  : the decremented field has become zero
//   allZero   out 1  : the whole decremented word is zero
module stage_decrementer
   import wash_pkg::*;
(
   input  logic [MSG_W-1:0] word,
   output logic [MSG_W-1:0] decWord,
   output logic             fieldZero,
   output logic             allZero
);

   logic [3:0] fld_s [8];
   logic [2:0] sel_s;
   logic       found_s;

   assign fld_s[7] = 4'(word[ST7_MSB:ST7_LSB]);
   assign fld_s[6] = 4'(word[ST6_MSB:ST6_LSB]);
   assign fld_s[5] = 4'(word[ST5_MSB:ST5_LSB]);
   assign fld_s[4] = 4'(word[ST4_MSB:ST4_LSB]);
   assign fld_s[3] = 4'(word[ST3_MSB:ST3_LSB]);
   assign fld_s[2] = 4'(word[ST2_MSB:ST2_LSB]);
   assign fld_s[1] = 4'(word[ST1_MSB:ST1_LSB]);
   assign fld_s[0] = 4'(word[ST0_MSB:ST0_LSB]);

   // Pick the highest-index non-zero field; later iterations override earlier ones.
   always_comb begin
      sel_s   = 3'd0;
      found_s = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (fld_s[i] != 4'd0) begin
            sel_s   = 3'(i);
            found_s = 1'b1;
         end else begin
            sel_s   = sel_s;
            found_s = found_s;
         end
      end
   end

   // Subtracting one at the field's LSB cannot borrow out of a non-zero field,
   // so this is exactly a decrement of that field at its own width.
   always_comb begin
      if (found_s) begin
         decWord   = word - (26'd1 << stage_lsb(sel_s));
         fieldZero = (fld_s[sel_s] == 4'd1);
      end else begin
         decWord   = word;
         fieldZero = 1'b0;
      end
      allZero = (decWord == 26'd0);
   end

endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: washing-machine programme sequencer.
// Latches the programme, counts it down one stage field per tick, and handles
// pause, error interlock, finish alarm and power toggling.
// Ports:
//   cp, reset        : clock, synchronous active-high reset
//   tick             : 1 Hz one-cycle strobe
//   powerBtn, setBtn, startBtn, pauseBtn : one-cycle button pulses
//   errIn            : door open / water fault level
//   sourceData [26]  : programme from setup logic
//   state [3]        : machine state code
//   msg [26]         : remaining time per stage
//   buzzer           : high while in finish
//   stageDone        : one-cycle pulse when a stage field reaches zero
module wash_sequencer
   import wash_pkg::*;
#(
   parameter int unsigned FINISH_TICKS = 5
)(
   input  logic             cp,
   input  logic             reset,
   input  logic             tick,
   input  logic             powerBtn,
   input  logic             setBtn,
   input  logic             startBtn,
   input  logic             pauseBtn,
   input  logic             errIn,
   input  logic [MSG_W-1:0] sourceData,
   output logic [2:0]       state,
   output logic [MSG_W-1:0] msg,
   output logic             buzzer,
   output logic             stageDone
);

   localparam int CNT_W = $clog2(FINISH_TICKS + 1) < 1 ? 1 : $clog2(FINISH_TICKS + 1);

   wash_state_e      state_r, state_nx_s;
   logic [MSG_W-1:0] msg_r, msg_nx_s;
   logic [CNT_W-1:0] cnt_r, cnt_nx_s;
   logic             buzzer_r;
   logic             stage_done_r, stage_done_nx_s;

   logic [MSG_W-1:0] dec_word_s;
   logic             field_zero_s;
   logic             all_zero_s;

   stage_decrementer u_dec (
      .word      (msg_r),
      .decWord   (dec_word_s),
      .fieldZero (field_zero_s),
      .allZero   (all_zero_s)
   );

   // Next-state, countdown and buzzer-counter logic.
   always_comb begin
      state_nx_s      = state_r;
      msg_nx_s        = msg_r;
      cnt_nx_s        = cnt_r;
      stage_done_nx_s = 1'b0;
      if (powerBtn) begin
         // Power toggles between shutDown and begin; any other state powers off.
         state_nx_s = (state_r == shutDownST) ? beginST : shutDownST;
         msg_nx_s   = 26'd0;
         cnt_nx_s   = {CNT_W{1'b0}};
      end else begin
         case (state_r)
            shutDownST: state_nx_s = shutDownST;
            beginST: begin
               if (setBtn) state_nx_s = setST;
               else        state_nx_s = beginST;
            end
            setST: begin
               if (startBtn && (sourceData != 26'd0)) begin
                  state_nx_s = runST;
                  msg_nx_s   = sourceData;
               end else begin
                  state_nx_s = setST;
               end
            end
            runST: begin
               // errIn outranks pauseBtn outranks tick; a lost tick is dropped.
               if (errIn) begin
                  state_nx_s = errorST;
               end else if (pauseBtn) begin
                  state_nx_s = pauseST;
               end else if (tick) begin
                  msg_nx_s        = dec_word_s;
                  stage_done_nx_s = field_zero_s;
                  if (all_zero_s) begin
                     state_nx_s = finishST;
                     cnt_nx_s   = CNT_W'(FINISH_TICKS);
                  end else begin
                     state_nx_s = runST;
                  end
               end else begin
                  state_nx_s = runST;
               end
            end
            errorST: begin
               if (!errIn) state_nx_s = pauseST;
               else        state_nx_s = errorST;
            end
            pauseST: begin
               if (startBtn) state_nx_s = errIn ? errorST : runST;
               else          state_nx_s = pauseST;
            end
            finishST: begin
               if (tick) begin
                  // Counter values of 0 or 1 both end the alarm on this tick.
                  if (cnt_r <= CNT_W'(1)) begin
                     state_nx_s = beginST;
                     cnt_nx_s   = {CNT_W{1'b0}};
                  end else begin
                     state_nx_s = finishST;
                     cnt_nx_s   = cnt_r - CNT_W'(1);
                  end
               end else begin
                  state_nx_s = finishST;
               end
            end
            default: begin
               state_nx_s = shutDownST;
               msg_nx_s   = 26'd0;
               cnt_nx_s   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // State, countdown word and registered outputs.
   always_ff @(posedge cp) begin
      if (reset) begin
         state_r      <= shutDownST;
         msg_r        <= 26'd0;
         cnt_r        <= {CNT_W{1'b0}};
         buzzer_r     <= 1'b0;
         stage_done_r <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         msg_r        <= msg_nx_s;
         cnt_r        <= cnt_nx_s;
         buzzer_r     <= (state_nx_s == finishST);
         stage_done_r <= stage_done_nx_s;
      end
   end

   assign state     = state_r;
   assign msg       = msg_r;
   assign buzzer    = buzzer_r;
   assign stageDone = stage_done_r;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed self-checking bench for wash_sequencer.
module tb_wash_sequencer;

   logic        cp = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic        powerBtn = 1'b0;
   logic        setBtn = 1'b0;
   logic        startBtn = 1'b0;
   logic        pauseBtn = 1'b0;
   logic        errIn = 1'b0;
   logic [25:0] sourceData = 26'd0;
   logic [2:0]  state;
   logic [25:0] msg;
   logic        buzzer;
   logic        stageDone;

   int vectors = 0;
   int miscompares = 0;

   wash_sequencer #(.FINISH_TICKS(5)) dut (
      .cp         (cp),
      .reset      (reset),
      .tick       (tick),
      .powerBtn   (powerBtn),
      .setBtn     (setBtn),
      .startBtn   (startBtn),
      .pauseBtn   (pauseBtn),
      .errIn      (errIn),
      .sourceData (sourceData),
      .state      (state),
      .msg        (msg),
      .buzzer     (buzzer),
      .stageDone  (stageDone)
   );

   always #5 cp = ~cp;

   // Advance one clock edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic cycle();
      @(posedge cp);
      #1;
      tick     = 1'b0;
      powerBtn = 1'b0;
      setBtn   = 1'b0;
      startBtn = 1'b0;
      pauseBtn = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset
      reset = 1'b1; cycle(); reset = 1'b0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_msg", 32'(msg), 32'd0);
      chk("rst_buzzer", 32'(buzzer), 32'd0);
      chk("rst_stagedone", 32'(stageDone), 32'd0);

      // Power on
      powerBtn = 1'b1; cycle();
      chk("pwr_state", 32'(state), 32'd1);
      chk("pwr_msg", 32'(msg), 32'd0);
      chk("pwr_buzzer", 32'(buzzer), 32'd0);

      // Set, then start with empty programme is ignored
      setBtn = 1'b1; cycle();
      chk("set_state", 32'(state), 32'd2);
      sourceData = 26'd0; startBtn = 1'b1; cycle();
      chk("zero_start_state", 32'(state), 32'd2);
      chk("zero_start_msg", 32'(msg), 32'd0);

      // Load stage7=2, stage0=1
      sourceData = 26'h1000001; startBtn = 1'b1; cycle();
      chk("load_state", 32'(state), 32'd3);
      chk("load_msg", 32'(msg), 32'h1000001);
      tick = 1'b1; cycle();
      chk("t1_msg", 32'(msg), 32'h0800001);
      chk("t1_stagedone", 32'(stageDone), 32'd0);
      tick = 1'b1; cycle();
      chk("t2_msg", 32'(msg), 32'h0000001);
      chk("t2_stagedone", 32'(stageDone), 32'd1);
      cycle();
      chk("idle_stagedone", 32'(stageDone), 32'd0);
      chk("idle_msg", 32'(msg), 32'h0000001);
      tick = 1'b1; cycle();
      chk("t3_msg", 32'(msg), 32'd0);
      chk("t3_state", 32'(state), 32'd6);
      chk("t3_buzzer", 32'(buzzer), 32'd1);
      chk("t3_stagedone", 32'(stageDone), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick = 1'b1; cycle();
      end
      chk("fin4_state", 32'(state), 32'd6);
      chk("fin4_buzzer", 32'(buzzer), 32'd1);
      tick = 1'b1; cycle();
      chk("fin5_state", 32'(state), 32'd1);
      chk("fin5_buzzer", 32'(buzzer), 32'd0);

      // Stage1=4, stage0=3; pause wins over tick
      setBtn = 1'b1; cycle();
      sourceData = 26'h0000023; startBtn = 1'b1; cycle();
      chk("load2_msg", 32'(msg), 32'h23);
      pauseBtn = 1'b1; tick = 1'b1; cycle();
      chk("pause_state", 32'(state), 32'd5);
      chk("pause_msg", 32'(msg), 32'h23);
      tick = 1'b1; cycle();
      chk("pause_tick_msg", 32'(msg), 32'h23);
      startBtn = 1'b1; cycle();
      chk("resume_state", 32'(state), 32'd3);
      tick = 1'b1; cycle();
      chk("resume_tick_msg", 32'(msg), 32'h1B);

      // Error outranks pause and tick
      errIn = 1'b1; pauseBtn = 1'b1; tick = 1'b1; cycle();
      chk("err_state", 32'(state), 32'd4);
      chk("err_msg", 32'(msg), 32'h1B);
      tick = 1'b1; cycle();
      chk("err_tick_state", 32'(state), 32'd4);
      chk("err_tick_msg", 32'(msg), 32'h1B);
      errIn = 1'b0; cycle();
      chk("err_clear_state", 32'(state), 32'd5);
      startBtn = 1'b1; cycle();
      chk("err_resume_state", 32'(state), 32'd3);
      tick = 1'b1; cycle();
      chk("err_resume_msg", 32'(msg), 32'h13);

      // Start from pause while fault present goes back to error
      pauseBtn = 1'b1; cycle();
      chk("pause2_state", 32'(state), 32'd5);
      errIn = 1'b1; startBtn = 1'b1; cycle();
      chk("pause_err_state", 32'(state), 32'd4);
      errIn = 1'b0; cycle();
      startBtn = 1'b1; cycle();
      chk("pause_err_resume", 32'(state), 32'd3);

      // Power off mid-run
      powerBtn = 1'b1; tick = 1'b1; cycle();
      chk("pwroff_state", 32'(state), 32'd0);
      chk("pwroff_msg", 32'(msg), 32'd0);

      // 4-bit fields: stage6=9, stage2=1
      powerBtn = 1'b1; cycle();
      setBtn = 1'b1; cycle();
      sourceData = 26'h0480040; startBtn = 1'b1; cycle();
      chk("load3_msg", 32'(msg), 32'h0480040);
      tick = 1'b1; cycle();
      chk("st6_dec_msg", 32'(msg), 32'h0400040);

      // Reset mid-run overrides everything
      reset = 1'b1; powerBtn = 1'b1; tick = 1'b1; cycle(); reset = 1'b0;
      chk("rst_run_state", 32'(state), 32'd0);
      chk("rst_run_msg", 32'(msg), 32'd0);
      chk("rst_run_buzzer", 32'(buzzer), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
